// File: rtl/mem_arbiter_if.sv
// Signal bundle between the memory arbiter, its IF/LS requesters and the memory port.
// The slave modport is the arbiter's view; master is the requester/memory environment.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned MASK_W = 8
);
  // Instruction-fetch requester
  logic              if_req_valid;
  logic              if_req_ready;
  logic [ADDR_W-1:0] if_addr;
  logic              if_resp_valid;
  logic [DATA_W-1:0] if_rdata;

  // Load/store requester
  logic              ls_req_valid;
  logic              ls_req_ready;
  logic              ls_wen;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic [MASK_W-1:0] ls_wmask;
  logic              ls_resp_valid;
  logic [DATA_W-1:0] ls_rdata;

  // Memory port
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [MASK_W-1:0] mem_wmask;
  logic              mem_resp_valid;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  modport slave (
    input  if_req_valid, if_addr,
    input  ls_req_valid, ls_wen, ls_addr, ls_wdata, ls_wmask,
    input  mem_req_ready, mem_resp_valid, mem_rdata,
    output if_req_ready, if_resp_valid, if_rdata,
    output ls_req_ready, ls_resp_valid, ls_rdata,
    output mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wmask,
    output busy
  );

  modport master (
    output if_req_valid, if_addr,
    output ls_req_valid, ls_wen, ls_addr, ls_wdata, ls_wmask,
    output mem_req_ready, mem_resp_valid, mem_rdata,
    input  if_req_ready, if_resp_valid, if_rdata,
    input  ls_req_ready, ls_resp_valid, ls_rdata,
    input  mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wmask,
    input  busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter sharing the data-memory port between IF and LS requesters.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is fixed LS-over-IF priority.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned MASK_W = 8
) (
  input logic           clk,
  input logic           rst,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

  state_e            state_q, state_d;
  logic              owner_ls_q, owner_ls_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wen_q, wen_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [MASK_W-1:0] mask_q, mask_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;

  logic grant_if, grant_ls;
  logic ls_prio;
  logic resp_fire;

`ifdef MEM_ARB_RR_EN
  // Pointer records who was granted last; on a tie the other requester wins.
  logic last_ls_q, last_ls_d;

  assign ls_prio = ~last_ls_q;

  always_comb begin
    last_ls_d = last_ls_q;
    if (grant_ls) begin
      last_ls_d = 1'b1;
    end else if (grant_if) begin
      last_ls_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_ls_q <= 1'b1;
    end else begin
      last_ls_q <= last_ls_d;
    end
  end
`else
  assign ls_prio = 1'b1;
`endif

  // Grant is combinational in IDLE and suppressed while reset is held.
  always_comb begin
    grant_ls = 1'b0;
    grant_if = 1'b0;
    if (state_q == StIdle && !rst) begin
      grant_ls = bus.ls_req_valid && (ls_prio || !bus.if_req_valid);
      grant_if = bus.if_req_valid && !grant_ls;
    end
  end

  assign resp_fire = (state_q == StResp) && bus.mem_resp_valid && !rst;

  always_comb begin
    state_d    = state_q;
    owner_ls_d = owner_ls_q;
    addr_d     = addr_q;
    wen_d      = wen_q;
    wdata_d    = wdata_q;
    mask_d     = mask_q;
    if_rdata_d = if_rdata_q;
    ls_rdata_d = ls_rdata_q;

    unique case (state_q)
      StIdle: begin
        if (grant_ls) begin
          state_d    = StReq;
          owner_ls_d = 1'b1;
          addr_d     = bus.ls_addr;
          wen_d      = bus.ls_wen;
          wdata_d    = bus.ls_wdata;
          mask_d     = bus.ls_wen ? bus.ls_wmask : '0;
        end else if (grant_if) begin
          state_d    = StReq;
          owner_ls_d = 1'b0;
          addr_d     = bus.if_addr;
          wen_d      = 1'b0;
          wdata_d    = '0;
          mask_d     = '0;
        end
      end
      StReq: begin
        if (bus.mem_req_ready) begin
          state_d = StResp;
        end
      end
      StResp: begin
        if (bus.mem_resp_valid) begin
          state_d = StIdle;
          if (owner_ls_q) begin
            ls_rdata_d = bus.mem_rdata;
          end else begin
            if_rdata_d = bus.mem_rdata;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      owner_ls_q <= 1'b0;
      addr_q     <= '0;
      wen_q      <= 1'b0;
      wdata_q    <= '0;
      mask_q     <= '0;
      if_rdata_q <= '0;
      ls_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_ls_q <= owner_ls_d;
      addr_q     <= addr_d;
      wen_q      <= wen_d;
      wdata_q    <= wdata_d;
      mask_q     <= mask_d;
      if_rdata_q <= if_rdata_d;
      ls_rdata_q <= ls_rdata_d;
    end
  end

  // Response data is forwarded combinationally in the response cycle, then held.
  always_comb begin
    bus.if_req_ready  = grant_if;
    bus.ls_req_ready  = grant_ls;
    bus.mem_req_valid = (state_q == StReq);
    bus.mem_wen       = (state_q == StReq) && wen_q;
    bus.mem_addr      = addr_q;
    bus.mem_wdata     = wdata_q;
    bus.mem_wmask     = mask_q;
    bus.if_resp_valid = resp_fire && !owner_ls_q;
    bus.ls_resp_valid = resp_fire && owner_ls_q;
    bus.if_rdata      = (resp_fire && !owner_ls_q) ? bus.mem_rdata : if_rdata_q;
    bus.ls_rdata      = (resp_fire && owner_ls_q) ? bus.mem_rdata : ls_rdata_q;
    bus.busy          = (state_q != StIdle);
  end

  a_grant_onehot: assert property (@(posedge clk) !(grant_if && grant_ls));

  a_req_stable: assert property (@(posedge clk) disable iff (rst)
    (state_q == StReq && !bus.mem_req_ready) |=> ($stable(addr_q) && $stable(mask_q)));

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model with its own sparse memory.
`timescale 1ns/1ps
module tb_mem_arbiter;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned MW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .MASK_W(MW)) bus ();

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MASK_W(MW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  bit last_ls = 1'b1;
  logic [31:0] mem_model [logic [31:0]];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.if_req_valid = 1'b0; bus.if_addr = '0;
    bus.ls_req_valid = 1'b0; bus.ls_wen = 1'b0; bus.ls_addr = '0;
    bus.ls_wdata = '0; bus.ls_wmask = '0;
    bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0; bus.mem_rdata = '0;
  endtask

  // Complete a transaction already in REQ: accept now, respond next cycle.
  task automatic finish_txn(input logic [31:0] d);
    bus.mem_req_ready = 1'b1;
    tick();
    bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b1; bus.mem_rdata = d;
    tick();
    bus.mem_resp_valid = 1'b0; bus.mem_rdata = '0;
  endtask

  function automatic bit exp_ls_wins(input bit iv, input bit lv);
    bit prio;
`ifdef MEM_ARB_RR_EN
    prio = !last_ls;
`else
    prio = 1'b1;
`endif
    return lv && (!iv || prio);
  endfunction

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    return mem_model.exists(a) ? mem_model[a] : (a ^ 32'h5A5A_0000);
  endfunction

  function automatic logic [31:0] rand_addr();
    return 32'h8000_0000 | (32'($urandom_range(0, 7)) << 2);
  endfunction

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    bus.if_req_valid = 1'b1; bus.ls_req_valid = 1'b1; bus.mem_resp_valid = 1'b1;
    tick(); tick();
    checks++;
    if (bus.if_req_ready !== 1'b0 || bus.ls_req_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready: got if=%b ls=%b want 0 0", bus.if_req_ready, bus.ls_req_ready);
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.mem_req_valid !== 1'b0 || bus.mem_wen !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl: got busy=%b mreq=%b wen=%b want 0 0 0",
                         bus.busy, bus.mem_req_valid, bus.mem_wen);
    end
    checks++;
    if (bus.mem_addr !== '0 || bus.mem_wdata !== '0 || bus.mem_wmask !== '0) begin
      errors++; $display("FAIL reset_mem: got addr=%h wdata=%h mask=%h want 0",
                         bus.mem_addr, bus.mem_wdata, bus.mem_wmask);
    end
    checks++;
    if (bus.if_rdata !== '0 || bus.ls_rdata !== '0 || bus.if_resp_valid !== 1'b0 ||
        bus.ls_resp_valid !== 1'b0) begin
      errors++; $display("FAIL reset_resp: got ifd=%h lsd=%h ifv=%b lsv=%b want 0",
                         bus.if_rdata, bus.ls_rdata, bus.if_resp_valid, bus.ls_resp_valid);
    end
    clear_inputs();
    rst = 1'b0; last_ls = 1'b1;
    tick();
  endtask

  task automatic test_ls_read();
    int busy_cnt = 0;
    clear_inputs();
    bus.ls_req_valid = 1'b1; bus.ls_wen = 1'b0; bus.ls_addr = 32'h8000_0010; bus.ls_wmask = 8'hFF;
    #1;
    checks++;
    if (bus.ls_req_ready !== 1'b1 || bus.if_req_ready !== 1'b0) begin
      errors++; $display("FAIL ls_read_grant: got ls=%b if=%b want 1 0", bus.ls_req_ready, bus.if_req_ready);
    end
    last_ls = 1'b1;
    tick();
    clear_inputs();
    bus.ls_addr = 32'hFFFF_FFF0; bus.mem_req_ready = 1'b1;
    #1;
    busy_cnt += int'(bus.busy);
    checks++;
    if (bus.mem_req_valid !== 1'b1 || bus.mem_addr !== 32'h8000_0010 || bus.mem_wen !== 1'b0 ||
        bus.mem_wmask !== 8'h00) begin
      errors++; $display("FAIL ls_read_req: got v=%b addr=%h wen=%b mask=%h want 1 80000010 0 00",
                         bus.mem_req_valid, bus.mem_addr, bus.mem_wen, bus.mem_wmask);
    end
    tick();
    bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b1; bus.mem_rdata = 32'hDEAD_BEEF;
    #1;
    busy_cnt += int'(bus.busy);
    checks++;
    if (bus.ls_resp_valid !== 1'b1 || bus.ls_rdata !== 32'hDEAD_BEEF || bus.if_resp_valid !== 1'b0) begin
      errors++; $display("FAIL ls_read_resp: got lsv=%b data=%h ifv=%b want 1 deadbeef 0",
                         bus.ls_resp_valid, bus.ls_rdata, bus.if_resp_valid);
    end
    tick();
    clear_inputs();
    #1;
    busy_cnt += int'(bus.busy);
    checks++;
    if (bus.ls_resp_valid !== 1'b0 || bus.ls_rdata !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL ls_read_hold: got lsv=%b data=%h want 0 deadbeef",
                         bus.ls_resp_valid, bus.ls_rdata);
    end
    checks++;
    if (busy_cnt != 2) begin
      errors++; $display("FAIL ls_read_busy: got %0d busy cycles want 2", busy_cnt);
    end
  endtask

  task automatic test_ls_write();
    clear_inputs();
    bus.ls_req_valid = 1'b1; bus.ls_wen = 1'b1; bus.ls_addr = 32'h8000_0004;
    bus.ls_wdata = 32'h1234_5678; bus.ls_wmask = 8'h03;
    #1;
    checks++;
    if (bus.ls_req_ready !== 1'b1) begin
      errors++; $display("FAIL ls_write_grant: got %b want 1", bus.ls_req_ready);
    end
    last_ls = 1'b1;
    tick();
    clear_inputs();
    bus.ls_addr = 32'hFFFF_FFFF; bus.ls_wdata = 32'hFFFF_FFFF; bus.ls_wmask = 8'hFF;
    for (int k = 0; k < 4; k++) begin
      bus.mem_req_ready = (k == 3);
      #1;
      checks++;
      if (bus.mem_req_valid !== 1'b1 || bus.mem_addr !== 32'h8000_0004 || bus.mem_wen !== 1'b1 ||
          bus.mem_wdata !== 32'h1234_5678 || bus.mem_wmask !== 8'h03) begin
        errors++; $display("FAIL ls_write_req%0d: got v=%b a=%h w=%b d=%h m=%h want 1 80000004 1 12345678 03",
                           k, bus.mem_req_valid, bus.mem_addr, bus.mem_wen, bus.mem_wdata, bus.mem_wmask);
      end
      tick();
    end
    bus.mem_req_ready = 1'b0;
    #1;
    checks++;
    if (bus.ls_resp_valid !== 1'b0 || bus.mem_req_valid !== 1'b0 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL ls_write_wait: got lsv=%b mreq=%b busy=%b want 0 0 1",
                         bus.ls_resp_valid, bus.mem_req_valid, bus.busy);
    end
    tick();
    bus.mem_resp_valid = 1'b1;
    #1;
    checks++;
    if (bus.ls_resp_valid !== 1'b1 || bus.if_resp_valid !== 1'b0) begin
      errors++; $display("FAIL ls_write_resp: got lsv=%b ifv=%b want 1 0", bus.ls_resp_valid, bus.if_resp_valid);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_both();
    bit w1, w2;
    clear_inputs();
    bus.if_req_valid = 1'b1; bus.if_addr = 32'h8000_0100;
    bus.ls_req_valid = 1'b1; bus.ls_addr = 32'h8000_0200;
    #1;
    w1 = exp_ls_wins(1'b1, 1'b1);
    checks++;
    if (bus.ls_req_ready !== w1 || bus.if_req_ready !== !w1) begin
      errors++; $display("FAIL both1_grant: got ls=%b if=%b want %b %b", bus.ls_req_ready,
                         bus.if_req_ready, w1, !w1);
    end
    last_ls = w1;
    tick();
    if (w1) bus.ls_req_valid = 1'b0; else bus.if_req_valid = 1'b0;
    #1;
    checks++;
    if (bus.mem_addr !== (w1 ? 32'h8000_0200 : 32'h8000_0100) || bus.if_req_ready !== 1'b0 ||
        bus.ls_req_ready !== 1'b0) begin
      errors++; $display("FAIL both1_req: got addr=%h if=%b ls=%b want %h 0 0", bus.mem_addr,
                         bus.if_req_ready, bus.ls_req_ready, w1 ? 32'h8000_0200 : 32'h8000_0100);
    end
    finish_txn(32'h1111_1111);
    #1;
    checks++;
    if ((w1 ? bus.if_req_ready : bus.ls_req_ready) !== 1'b1) begin
      errors++; $display("FAIL both_loser_grant: got if=%b ls=%b want loser=1", bus.if_req_ready,
                         bus.ls_req_ready);
    end
    last_ls = !w1;
    tick();
    bus.if_req_valid = 1'b0; bus.ls_req_valid = 1'b0;
    finish_txn(32'h2222_2222);
    bus.if_req_valid = 1'b1; bus.ls_req_valid = 1'b1;
    #1;
    w2 = exp_ls_wins(1'b1, 1'b1);
    checks++;
    if (bus.ls_req_ready !== w2 || bus.if_req_ready !== !w2) begin
      errors++; $display("FAIL both2_grant: got ls=%b if=%b want %b %b", bus.ls_req_ready,
                         bus.if_req_ready, w2, !w2);
    end
    last_ls = w2;
    tick();
    clear_inputs();
    finish_txn(32'h3333_3333);
  endtask

  task automatic test_stray();
    clear_inputs();
    bus.mem_resp_valid = 1'b1; bus.mem_rdata = 32'hBAD0_0001;
    #1;
    checks++;
    if (bus.if_resp_valid !== 1'b0 || bus.ls_resp_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL stray_idle: got ifv=%b lsv=%b busy=%b want 0 0 0",
                         bus.if_resp_valid, bus.ls_resp_valid, bus.busy);
    end
    tick();
    bus.mem_resp_valid = 1'b0;
    bus.if_req_valid = 1'b1; bus.if_addr = 32'h8000_0040;
    #1;
    checks++;
    if (bus.if_req_ready !== 1'b1) begin
      errors++; $display("FAIL stray_grant: got %b want 1", bus.if_req_ready);
    end
    last_ls = 1'b0;
    tick();
    clear_inputs();
    bus.mem_resp_valid = 1'b1; bus.mem_rdata = 32'hBAD0_0002;
    #1;
    checks++;
    if (bus.if_resp_valid !== 1'b0 || bus.mem_req_valid !== 1'b1) begin
      errors++; $display("FAIL stray_req: got ifv=%b mreq=%b want 0 1", bus.if_resp_valid, bus.mem_req_valid);
    end
    tick();
    #1;
    checks++;
    if (bus.mem_req_valid !== 1'b1 || bus.if_resp_valid !== 1'b0 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL stray_req_hold: got mreq=%b ifv=%b busy=%b want 1 0 1",
                         bus.mem_req_valid, bus.if_resp_valid, bus.busy);
    end
    bus.mem_resp_valid = 1'b0;
    finish_txn(32'h4444_4444);
    #1;
    checks++;
    if (bus.if_rdata !== 32'h4444_4444) begin
      errors++; $display("FAIL stray_data: got %h want 44444444", bus.if_rdata);
    end
  endtask

  task automatic test_reset_mid();
    clear_inputs();
    bus.if_req_valid = 1'b1; bus.if_addr = 32'h8000_0080;
    tick();
    last_ls = 1'b0;
    clear_inputs();
    bus.mem_req_ready = 1'b1;
    tick();
    bus.mem_req_ready = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.if_resp_valid !== 1'b0) begin
      errors++; $display("FAIL rstmid_resp: got %b want 0", bus.if_resp_valid);
    end
    tick();
    rst = 1'b0; last_ls = 1'b1;
    bus.mem_resp_valid = 1'b1; bus.mem_rdata = 32'hCAFE_F00D;
    #1;
    checks++;
    if (bus.if_resp_valid !== 1'b0 || bus.busy !== 1'b0 || bus.mem_req_valid !== 1'b0 ||
        bus.mem_addr !== '0 || bus.if_rdata !== '0) begin
      errors++; $display("FAIL rstmid_idle: got ifv=%b busy=%b mreq=%b addr=%h ifd=%h want 0",
                         bus.if_resp_valid, bus.busy, bus.mem_req_valid, bus.mem_addr, bus.if_rdata);
    end
    tick();
    bus.mem_resp_valid = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.if_resp_valid !== 1'b0) begin
      errors++; $display("FAIL rstmid_after: got busy=%b ifv=%b want 0 0", bus.busy, bus.if_resp_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [2];
    logic [31:0] got [2];
    int gcyc [2];
    int ng = 0;
    int nr = 0;
    bit resp_due = 1'b0;
    logic [31:0] due_addr = '0;
    addrs[0] = 32'h8000_0000; addrs[1] = 32'h8000_0004;
    got[0] = '0; got[1] = '0; gcyc[0] = 0; gcyc[1] = 0;
    clear_inputs();
    for (int c = 0; c < 16; c++) begin
      bus.mem_req_ready = 1'b1;
      bus.if_req_valid = (ng < 2);
      bus.if_addr = (ng < 2) ? addrs[ng] : '0;
      bus.mem_resp_valid = resp_due;
      bus.mem_rdata = resp_due ? mem_read(due_addr) : 32'h0;
      #1;
      if (bus.if_resp_valid) begin
        if (nr < 2) got[nr] = bus.if_rdata;
        nr++;
      end
      resp_due = bus.mem_req_valid && bus.mem_req_ready;
      due_addr = bus.mem_addr;
      if (bus.if_req_ready && ng < 2) begin
        gcyc[ng] = c; ng++; last_ls = 1'b0;
      end
      tick();
    end
    clear_inputs();
    checks++;
    if (ng != 2 || nr != 2) begin
      errors++; $display("FAIL b2b_counts: got grants=%0d resps=%0d want 2 2", ng, nr);
    end
    checks++;
    if (gcyc[1] - gcyc[0] != 3) begin
      errors++; $display("FAIL b2b_spacing: got %0d cycles want 3", gcyc[1] - gcyc[0]);
    end
    checks++;
    if (got[0] !== mem_read(addrs[0]) || got[1] !== mem_read(addrs[1])) begin
      errors++; $display("FAIL b2b_data: got %h %h want %h %h", got[0], got[1],
                         mem_read(addrs[0]), mem_read(addrs[1]));
    end
  endtask

  task automatic drive_reqs(input bit ip, input logic [31:0] ia, input bit lp, input logic [31:0] la,
                            input bit lw, input logic [31:0] lwd, input logic [7:0] lm);
    bus.if_req_valid = ip; bus.if_addr = ip ? ia : $urandom;
    bus.ls_req_valid = lp; bus.ls_addr = lp ? la : $urandom;
    bus.ls_wen = lp ? lw : 1'($urandom); bus.ls_wdata = lp ? lwd : $urandom;
    bus.ls_wmask = lp ? lm : 8'($urandom);
  endtask

  task automatic test_random(input int n);
    bit ip = 1'b0, lp = 1'b0, win_ls, ew, if_known = 1'b0, ls_known = 1'b0;
    logic [31:0] ia = '0, la = '0, lwd = '0, ea, ewd, rd, nv, exp_if_rd = '0, exp_ls_rd = '0;
    logic lw = 1'b0;
    logic [7:0] lm = '0, em;
    int d, r;
    for (int t = 0; t < n; t++) begin
      if (!ip && $urandom_range(0, 2) != 0) begin ip = 1'b1; ia = rand_addr(); end
      if (!lp && $urandom_range(0, 2) != 0) begin
        lp = 1'b1; la = rand_addr(); lw = 1'($urandom_range(0, 1)); lwd = $urandom;
        lm = 8'($urandom_range(0, 255));
      end
      if (!ip && !lp) begin ip = 1'b1; ia = rand_addr(); end
      clear_inputs();
      drive_reqs(ip, ia, lp, la, lw, lwd, lm);
      bus.mem_resp_valid = 1'($urandom_range(0, 1)); bus.mem_rdata = $urandom;
      #1;
      win_ls = exp_ls_wins(ip, lp);
      checks++;
      if (bus.ls_req_ready !== win_ls || bus.if_req_ready !== !win_ls || bus.busy !== 1'b0 ||
          bus.if_resp_valid !== 1'b0 || bus.ls_resp_valid !== 1'b0) begin
        errors++; $display("FAIL rnd%0d_grant: got ls=%b if=%b busy=%b rv=%b%b want %b %b 0 00", t,
                           bus.ls_req_ready, bus.if_req_ready, bus.busy, bus.if_resp_valid,
                           bus.ls_resp_valid, win_ls, !win_ls);
      end
      if (if_known) begin
        checks++;
        if (bus.if_rdata !== exp_if_rd) begin
          errors++; $display("FAIL rnd%0d_if_hold: got %h want %h", t, bus.if_rdata, exp_if_rd);
        end
      end
      if (ls_known) begin
        checks++;
        if (bus.ls_rdata !== exp_ls_rd) begin
          errors++; $display("FAIL rnd%0d_ls_hold: got %h want %h", t, bus.ls_rdata, exp_ls_rd);
        end
      end
      if (win_ls) begin
        ea = la; ew = lw; ewd = lwd; em = lw ? lm : 8'h00; lp = 1'b0;
      end else begin
        ea = ia; ew = 1'b0; ewd = '0; em = 8'h00; ip = 1'b0;
      end
      last_ls = win_ls;
      tick();
      d = $urandom_range(0, 2);
      for (int k = 0; k <= d; k++) begin
        drive_reqs(ip, ia, lp, la, lw, lwd, lm);
        bus.mem_req_ready = (k == d);
        bus.mem_resp_valid = 1'($urandom_range(0, 1)); bus.mem_rdata = $urandom;
        #1;
        checks++;
        if (bus.mem_req_valid !== 1'b1 || bus.mem_addr !== ea || bus.mem_wen !== ew ||
            bus.mem_wmask !== em || (ew && bus.mem_wdata !== ewd) || bus.if_req_ready !== 1'b0 ||
            bus.ls_req_ready !== 1'b0 || bus.if_resp_valid !== 1'b0 || bus.ls_resp_valid !== 1'b0 ||
            bus.busy !== 1'b1) begin
          errors++; $display("FAIL rnd%0d_req: got v=%b a=%h w=%b d=%h m=%h rdy=%b%b rv=%b%b want 1 %h %b %h %h 00 00",
                             t, bus.mem_req_valid, bus.mem_addr, bus.mem_wen, bus.mem_wdata,
                             bus.mem_wmask, bus.if_req_ready, bus.ls_req_ready, bus.if_resp_valid,
                             bus.ls_resp_valid, ea, ew, ewd, em);
        end
        tick();
      end
      r = $urandom_range(0, 2);
      rd = ew ? $urandom : mem_read(ea);
      for (int k = 0; k <= r; k++) begin
        drive_reqs(ip, ia, lp, la, lw, lwd, lm);
        bus.mem_req_ready = 1'($urandom_range(0, 1));
        bus.mem_resp_valid = (k == r);
        bus.mem_rdata = (k == r) ? rd : $urandom;
        #1;
        checks++;
        if (bus.mem_req_valid !== 1'b0 ||
            bus.ls_resp_valid !== ((k == r) && win_ls) ||
            bus.if_resp_valid !== ((k == r) && !win_ls) ||
            ((k == r) && ((win_ls ? bus.ls_rdata : bus.if_rdata) !== rd))) begin
          errors++; $display("FAIL rnd%0d_resp%0d: got mreq=%b lsv=%b ifv=%b lsd=%h ifd=%h want owner_ls=%b data=%h",
                             t, k, bus.mem_req_valid, bus.ls_resp_valid, bus.if_resp_valid,
                             bus.ls_rdata, bus.if_rdata, win_ls, rd);
        end
        tick();
      end
      if (ew) begin
        nv = mem_read(ea);
        for (int b = 0; b < 4; b++) begin
          if (em[b]) nv[8*b +: 8] = ewd[8*b +: 8];
        end
        mem_model[ea] = nv;
      end
      if (win_ls) begin exp_ls_rd = rd; ls_known = 1'b1; end
      else begin exp_if_rd = rd; if_known = 1'b1; end
    end
    clear_inputs();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_ls_read();
    test_ls_write();
    test_both();
    test_stray();
    test_reset_mid();
    test_back_to_back();
    test_random(200);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion want finish before 500us");
    $fatal(1, "timeout");
  end

endmodule
